data_bus_bridge: RTL

- Memory-stage data-side bridge sitting directly downstream of the pipelined MIPS core.
- Consumes the core's M-stage data access (address, write data, 4-bit byte write enables, load size).
- Converts it into a handshaked SRAM-like bus transaction with variable latency.
- Returns load data to the core and asserts a stall until the access completes.

---
 rtl/data_bus_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: memory-stage data-side bridge between the pipelined MIPS core and an
// SRAM-like handshaked bus with variable latency.
//
// The core's M-stage access is captured on issue, presented on the bus until accepted
// (bus_addr_ok), then the bridge waits for bus_data_ok and returns load data. The core is
// stalled until the access completes. If the pipeline is frozen for another reason
// (cpu_longstall) when the response arrives, the data is parked in a register and replayed
// without re-issuing the access.
//
// Optional feature (macro ALIGN_CHECK_EN): when defined, misaligned half/word accesses raise
// adel (load) or ades (store) for the issue cycle and never reach the bus. When undefined,
// adel/ades are tied low and every access goes to the bus unchanged.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   cpu_en           M-stage instruction is a load or store
//   cpu_wen          byte write enables (0000 = load)
//   cpu_size         0 byte, 1 half, 2 word
//   cpu_addr         virtual address
//   cpu_wdata        lane-aligned store data
//   cpu_longstall    pipeline frozen for another reason
//   cpu_rdata        load data to the core
//   stall            hold M stage and upstream
//   adel, ades       load / store address error
//   bus_req..wdata   request channel (fields stable for the whole transaction)
//   bus_addr_ok      request accepted
//   bus_data_ok      read data / write ack valid
//   bus_rdata        read data
module data_bus_bridge #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] cpu_wdata,
    input  logic              cpu_longstall,
    output logic [ADDR_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              adel,
    output logic              ades,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [ADDR_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } stateT;

    stateT             stateQ, stateD;
    logic [ADDR_W-1:0] rdataQ, rdataD;
    logic              loadFields;
    logic              misaligned;

    logic              wrQ;
    logic [1:0]        sizeQ;
    logic [ADDR_W-1:0] addrQ;
    logic [3:0]        wstrbQ;
    logic [ADDR_W-1:0] wdataQ;

`ifdef ALIGN_CHECK_EN
    assign misaligned = ((cpu_size == 2'd1) && cpu_addr[0]) ||
                        ((cpu_size == 2'd2) && (cpu_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ <= StIdle;
            rdataQ <= '0;
            wrQ    <= 1'b0;
            sizeQ  <= 2'd0;
            addrQ  <= '0;
            wstrbQ <= 4'd0;
            wdataQ <= '0;
        end else begin
            stateQ <= stateD;
            rdataQ <= rdataD;
            // Fields are captured only on issue so they stay stable while the core's
            // M-stage inputs are free to wander during the transaction.
            if (loadFields) begin
                wrQ    <= |cpu_wen;
                sizeQ  <= cpu_size;
                addrQ  <= cpu_addr & ADDR_MASK;
                wstrbQ <= cpu_wen;
                wdataQ <= cpu_wdata;
            end
        end
    end

    always_comb begin
        stateD     = stateQ;
        rdataD     = rdataQ;
        loadFields = 1'b0;
        stall      = 1'b0;
        bus_req    = 1'b0;
        cpu_rdata  = '0;
        adel       = 1'b0;
        ades       = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (cpu_en) begin
                    if (misaligned) begin
                        adel = (cpu_wen == 4'd0);
                        ades = (cpu_wen != 4'd0);
                    end else begin
                        stall      = 1'b1;
                        loadFields = 1'b1;
                        stateD     = StAddr;
                    end
                end
            end
            StAddr: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                if (bus_addr_ok) begin
                    stateD = StData;
                end
            end
            StData: begin
                stall = !bus_data_ok;
                if (bus_data_ok) begin
                    if (cpu_longstall) begin
                        // Core cannot take the data now; park it for replay in StDone.
                        rdataD = bus_rdata;
                        stateD = StDone;
                    end else begin
                        cpu_rdata = bus_rdata;
                        stateD    = StIdle;
                    end
                end
            end
            StDone: begin
                // M stage is frozen on the same access: replay data, never re-issue.
                cpu_rdata = rdataQ;
                if (!cpu_longstall) begin
                    stateD = StIdle;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    assign bus_wr    = wrQ;
    assign bus_size  = sizeQ;
    assign bus_addr  = addrQ;
    assign bus_wstrb = wstrbQ;
    assign bus_wdata = wdataQ;

endmodule
